// File: rtl/dcache_pkg.sv
// dcache_pkg: types and helpers shared by the L1 data cache controller and its
// storage array.
//   state_e      controller FSM states
//   OFFSET_W     byte-offset width within a 32-byte line
//   WORD_SEL_W   word-select width (8 words per line)
//   WORD_W       CPU word width
//   get_idx()    line index field of a byte address
//   get_tag()    tag field of a byte address
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_ALLOC = 2'd2,
    ST_RETRY = 2'd3
  } state_e;

  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int WORD_W     = 32;

  // Both helpers return a zero-extended 32-bit field; callers size-cast.
  function automatic logic [31:0] get_idx(input logic [31:0] addr, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (addr >> OFFSET_W) & mask;
  endfunction

  function automatic logic [31:0] get_tag(input logic [31:0] addr, input int idx_w);
    return addr >> (OFFSET_W + idx_w);
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: register-based storage for the direct-mapped data cache.
// Holds per-line valid, dirty, tag and data. One combinational read port and
// one write port; the write port either installs a whole line (valid=1,
// dirty=0) or updates a single word (dirty=1).
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset (valid/dirty only)
//   rd_idx_i              read line index
//   rd_valid_o/dirty_o    state of the addressed line
//   rd_tag_o, rd_data_o   tag and data of the addressed line
//   line_we_i             install wr_tag_i / wr_line_i at wr_idx_i
//   word_we_i             write wr_word_i into word wr_word_sel_i of wr_idx_i
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int IDX_W     = 4,
  parameter int TAG_W     = 23,
  parameter int LINE_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_BITS-1:0]  rd_data_o,
  input  logic                  line_we_i,
  input  logic                  word_we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [TAG_W-1:0]      wr_tag_i,
  input  logic [LINE_BITS-1:0]  wr_line_i,
  input  logic [WORD_SEL_W-1:0] wr_word_sel_i,
  input  logic [WORD_W-1:0]     wr_word_i
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] data_d [NUM_LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (line_we_i) begin
      valid_d[wr_idx_i] = 1'b1;
      dirty_d[wr_idx_i] = 1'b0;
      tag_d[wr_idx_i]   = wr_tag_i;
      data_d[wr_idx_i]  = wr_line_i;
    end
    if (word_we_i) begin
      data_d[wr_idx_i][{wr_word_sel_i, 5'b0} +: WORD_W] = wr_word_i;
      dirty_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache
// sitting between the CPU MEM stage and a line-wide data memory.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-low reset
//   cpu_req_i/we_i/addr_i/data_i  MEM-stage access (held stable while stalled)
//   cpu_data_o, cpu_stall_o       load data, pipeline freeze
//   mem_req_o/we_o/addr_o/data_o  registered line request to memory
//   mem_data_i, mem_ack_i         fetched line, one-cycle completion pulse
//   hit_cnt_o, miss_cnt_o         saturating hit / miss counters
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | serve hits; a miss stalls and launches WB or ALLOC
// ST_WB    | write dirty victim line back to memory
// ST_ALLOC | fetch requested line; install it on ack
// ST_RETRY | one stall cycle so the held request re-accesses and hits
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_e state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_q, mem_data_d;
  logic [31:0]          hit_cnt_q, hit_cnt_d;
  logic [31:0]          miss_cnt_q, miss_cnt_d;
  // High in the IDLE cycle right after RETRY: that hit is the replay of a miss.
  logic                 reaccess_q, reaccess_d;

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic                  rd_valid, rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_data;
  logic                  hit;
  logic                  stall;
  logic [31:0]           load_word;
  logic                  line_we, word_we;
  logic                  unused_addr_bits;

  assign req_idx  = IDX_W'(get_idx(32'(cpu_addr_i), IDX_W));
  assign req_tag  = TAG_W'(get_tag(32'(cpu_addr_i), IDX_W));
  assign word_sel = cpu_addr_i[OFFSET_W-1:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .rd_idx_i      (req_idx),
    .rd_valid_o    (rd_valid),
    .rd_dirty_o    (rd_dirty),
    .rd_tag_o      (rd_tag),
    .rd_data_o     (rd_data),
    .line_we_i     (line_we),
    .word_we_i     (word_we),
    .wr_idx_i      (req_idx),
    .wr_tag_i      (req_tag),
    .wr_line_i     (mem_data_i),
    .wr_word_sel_i (word_sel),
    .wr_word_i     (cpu_data_i)
  );

  assign hit       = cpu_req_i & rd_valid & (rd_tag == req_tag);
  assign load_word = rd_data[{word_sel, 5'b0} +: 32];

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    reaccess_d = 1'b0;
    stall      = 1'b1;
    line_we    = 1'b0;
    word_we    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stall = cpu_req_i & ~hit;
        if (hit) begin
          word_we = cpu_we_i;
          if (!reaccess_q && hit_cnt_q != 32'hFFFF_FFFF)
            hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (cpu_req_i) begin
          if (miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_d = miss_cnt_q + 32'd1;
          mem_req_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d    = ST_WB;
            mem_we_d   = 1'b1;
            mem_addr_d = {rd_tag, req_idx, {OFFSET_W{1'b0}}};
            mem_data_d = rd_data;
          end else begin
            state_d    = ST_ALLOC;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
            mem_data_d = '0;
          end
        end
      end
      ST_WB: begin
        // Request stays up across WB->ALLOC; only the direction flips.
        if (mem_ack_i) begin
          state_d    = ST_ALLOC;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
          mem_data_d = '0;
        end
      end
      ST_ALLOC: begin
        if (mem_ack_i) begin
          state_d    = ST_RETRY;
          line_we    = 1'b1;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = '0;
        end
      end
      ST_RETRY: begin
        state_d    = ST_IDLE;
        reaccess_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Nothing leaves the cache while reset is held.
    if (!rst_i) begin
      line_we = 1'b0;
      word_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      reaccess_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      reaccess_q <= reaccess_d;
    end
  end

  assign cpu_stall_o = rst_i & stall;
  assign cpu_data_o  = (rst_i && state_q == ST_IDLE && hit && !cpu_we_i) ? load_word : 32'd0;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed testbench for dcache_controller. A single initial block walks a
// fixed sequence of accesses; a small memory responder inside the access task
// acks each phase after a chosen number of request cycles. Memory line at
// line address A holds words ((A>>6)<<8)+i.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o, mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;
  logic [31:0]  hit_cnt_o, miss_cnt_o;

  int tests = 0;
  int fails = 0;

  int           wb_cycles, noreq_cycles;
  logic [31:0]  wb_addr_seen, alloc_addr_seen;
  logic [255:0] wb_data_seen;
  int           st;
  logic [31:0]  rd;

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_line(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ((a >> 6) << 8) + 32'(i);
    return l;
  endfunction

  // Entered and left on a falling edge. Counts stall cycles, answers memory
  // requests after ack_delay request cycles per phase, returns the load word.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_delay, output int stalls, output logic [31:0] rdata);
    int phase;
    int guard;
    stalls = 0; phase = 0; guard = 0;
    wb_cycles = 0; noreq_cycles = 0;
    wb_addr_seen = '0; alloc_addr_seen = '0; wb_data_seen = '0;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
    #1;
    while (cpu_stall_o === 1'b1 && guard < 100) begin
      stalls++;
      if (mem_req_o === 1'b1) begin
        phase++;
        if (mem_we_o === 1'b1) begin
          wb_cycles++;
          wb_addr_seen = mem_addr_o;
          wb_data_seen = mem_data_o;
        end else begin
          alloc_addr_seen = mem_addr_o;
        end
        if (phase == ack_delay) begin
          mem_ack_i  = 1'b1;
          mem_data_i = model_line(mem_addr_o);
          phase      = 0;
        end
      end else begin
        noreq_cycles++;
      end
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
      guard++;
    end
    chk("stall_bounded", 256'(guard < 100), 256'(1));
    rdata = cpu_data_o;
    @(negedge clk_i);
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_mem_req", 256'(mem_req_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_stall", 256'(cpu_stall_o), 256'(0));
    chk("rst_hit_cnt", 256'(hit_cnt_o), 256'(0));
    chk("rst_miss_cnt", 256'(miss_cnt_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Cold load: clean miss, ack on 3rd request cycle -> 1 + 3 + 1 stalls.
    access(1'b0, 32'h40, 32'h0, 3, st, rd);
    chk("cold_stalls", 256'(st), 256'(5));
    chk("cold_data", 256'(rd), 256'(32'h100));
    chk("cold_alloc_addr", 256'(alloc_addr_seen), 256'(32'h40));
    chk("cold_no_wb", 256'(wb_cycles), 256'(0));
    chk("cold_miss_cnt", 256'(miss_cnt_o), 256'(1));
    chk("cold_hit_cnt", 256'(hit_cnt_o), 256'(0));

    access(1'b0, 32'h44, 32'h0, 3, st, rd);
    chk("hit_stalls", 256'(st), 256'(0));
    chk("hit_data", 256'(rd), 256'(32'h101));
    chk("hit_cnt_1", 256'(hit_cnt_o), 256'(1));

    access(1'b1, 32'h48, 32'hDEAD_BEEF, 3, st, rd);
    chk("store_hit_stalls", 256'(st), 256'(0));
    chk("hit_cnt_2", 256'(hit_cnt_o), 256'(2));

    // Conflict miss on index 2 with dirty victim: WB then ALLOC, 2 cycles each.
    access(1'b0, 32'h248, 32'h0, 2, st, rd);
    chk("wb_stalls", 256'(st), 256'(6));
    chk("wb_cycles", 256'(wb_cycles), 256'(2));
    chk("wb_addr", 256'(wb_addr_seen), 256'(32'h40));
    chk("wb_word2", 256'(wb_data_seen[95:64]), 256'(32'hDEAD_BEEF));
    chk("wb_word0", 256'(wb_data_seen[31:0]), 256'(32'h100));
    chk("alloc_addr", 256'(alloc_addr_seen), 256'(32'h240));
    chk("wb_noreq_cycles", 256'(noreq_cycles), 256'(2));
    chk("wb_data", 256'(rd), 256'(32'h902));
    chk("miss_cnt_2", 256'(miss_cnt_o), 256'(2));
    chk("hit_cnt_after_wb", 256'(hit_cnt_o), 256'(2));

    // Spurious ack while idle, no request.
    mem_ack_i = 1'b1; mem_data_i = '1;
    #1;
    chk("idle_no_req_data", 256'(cpu_data_o), 256'(0));
    chk("idle_no_req_stall", 256'(cpu_stall_o), 256'(0));
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("spurious_mem_req", 256'(mem_req_o), 256'(0));
    chk("spurious_miss_cnt", 256'(miss_cnt_o), 256'(2));
    chk("spurious_hit_cnt", 256'(hit_cnt_o), 256'(2));
    @(negedge clk_i);
    access(1'b0, 32'h24C, 32'h0, 2, st, rd);
    chk("post_spurious_stalls", 256'(st), 256'(0));
    chk("post_spurious_data", 256'(rd), 256'(32'h903));
    chk("hit_cnt_3", 256'(hit_cnt_o), 256'(3));

    // Store miss: write-allocate, word merged on the replay.
    access(1'b1, 32'h260, 32'hCAFE_F00D, 1, st, rd);
    chk("store_miss_stalls", 256'(st), 256'(3));
    chk("miss_cnt_3", 256'(miss_cnt_o), 256'(3));
    chk("store_replay_not_hit", 256'(hit_cnt_o), 256'(3));
    access(1'b0, 32'h260, 32'h0, 1, st, rd);
    chk("store_alloc_word", 256'(rd), 256'(32'hCAFE_F00D));
    access(1'b0, 32'h264, 32'h0, 1, st, rd);
    chk("store_alloc_neighbour", 256'(rd), 256'(32'h901));
    chk("hit_cnt_5", 256'(hit_cnt_o), 256'(5));

    // Reset in the middle of ALLOC.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80;
    repeat (2) @(negedge clk_i);
    #1;
    chk("alloc_req_before_rst", 256'(mem_req_o), 256'(1));
    chk("alloc_addr_before_rst", 256'(mem_addr_o), 256'(32'h80));
    rst_i = 1'b0;
    #1;
    chk("in_rst_stall", 256'(cpu_stall_o), 256'(0));
    @(negedge clk_i);
    #1;
    chk("rst_alloc_mem_req", 256'(mem_req_o), 256'(0));
    chk("rst_alloc_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_alloc_mem_data", mem_data_o, 256'(0));
    chk("rst_alloc_stall", 256'(cpu_stall_o), 256'(0));
    chk("rst_alloc_data", 256'(cpu_data_o), 256'(0));
    chk("rst_alloc_miss_cnt", 256'(miss_cnt_o), 256'(0));
    chk("rst_alloc_hit_cnt", 256'(hit_cnt_o), 256'(0));
    rst_i = 1'b1; cpu_req_i = 1'b0;
    mem_ack_i = 1'b1; mem_data_i = '1;
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_ignored", 256'(mem_req_o), 256'(0));
    @(negedge clk_i);

    access(1'b0, 32'h80, 32'h0, 2, st, rd);
    chk("reload_stalls", 256'(st), 256'(4));
    chk("reload_data", 256'(rd), 256'(32'h200));
    chk("reload_miss_cnt", 256'(miss_cnt_o), 256'(1));
    chk("reload_hit_cnt", 256'(hit_cnt_o), 256'(0));
    // Index 3 was dirty before reset; reset must leave it invalid and clean.
    access(1'b0, 32'h264, 32'h0, 2, st, rd);
    chk("post_rst_clean_stalls", 256'(st), 256'(4));
    chk("post_rst_no_wb", 256'(wb_cycles), 256'(0));
    chk("post_rst_data", 256'(rd), 256'(32'h901));
    chk("post_rst_miss_cnt", 256'(miss_cnt_o), 256'(2));

    // Hit counter saturation.
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk_i);
    release dut.hit_cnt_q;
    @(negedge clk_i);
    access(1'b0, 32'h84, 32'h0, 2, st, rd);
    chk("sat_data", 256'(rd), 256'(32'h201));
    chk("sat_reach_max", 256'(hit_cnt_o), 256'(32'hFFFF_FFFF));
    access(1'b0, 32'h88, 32'h0, 2, st, rd);
    chk("sat_hold", 256'(hit_cnt_o), 256'(32'hFFFF_FFFF));
    chk("sat_data2", 256'(rd), 256'(32'h202));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the pipelined CPU's MEM stage and a slow, line-wide data memory.
- Replaces the CPU's direct data-memory access: the MEM stage presents a request, and the cache either serves it on a hit or stalls the whole pipeline while it runs a writeback/refill handshake with memory.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two; index width IDX_W = log2(NUM_LINES).
- LINE_BITS, 256, line size in bits (32 bytes, 8 words); fixed offset width 5.
- ADDR_W, 32, byte address width; tag width TAG_W = ADDR_W - 5 - IDX_W (23 at defaults).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- cpu_req_i  in  1  MEM stage access valid (MemRead or MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid when cpu_req_i=1, cpu_we_i=0, cpu_stall_o=0.
- cpu_stall_o  out  1  freeze PC and all pipeline registers.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = line writeback, 0 = line fetch.
- mem_addr_o  out  ADDR_W  line address; bits [4:0] are 0.
- mem_data_o  out  LINE_BITS  writeback line.
- mem_data_i  in  LINE_BITS  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse; honoured only while mem_req_o=1.
- hit_cnt_o  out  32  hit counter.
- miss_cnt_o  out  32  miss counter.

Behaviour:
- Address fields: word select = addr[4:2]; index = addr[5+IDX_W-1:5]; tag = addr[ADDR_W-1:5+IDX_W].
- Per-line storage: valid, dirty, tag, data. Array storage is registers, with no reset on data or tag.
- hit = cpu_req_i & valid[idx] & (tag[idx] == addr tag); evaluated combinationally.
- State machine (shared package enum): IDLE, WB, ALLOC, RETRY.
- IDLE:
  - Hit on a load: cpu_data_o = selected word in the same cycle; stall=0.
  - Hit on a store: write cpu_data_i into the selected word at the edge, set dirty; stall=0.
  - Miss: stall=1 combinationally in the same cycle. Go to WB if the victim is valid and dirty, else go to ALLOC.
- WB:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim line.
  - On mem_ack_i, go to ALLOC.
- ALLOC:
  - Outputs: mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, index, 5'b0}.
  - On mem_ack_i, capture mem_data_i, set valid, clear dirty, write tag, then go to RETRY.
- RETRY: one cycle with stall=1 and no memory request; then go to IDLE, where the held request hits.
- Stall timing: stall=1 in every state other than IDLE, and in IDLE on a miss.
- Miss penalty (clean victim, ack k cycles after request): 1 (ALLOC entry) + k + 1 (RETRY).
- Memory request outputs are registered. mem_req_o rises on the edge that enters WB/ALLOC and falls on the edge where ack is sampled.
- The WB to ALLOC transition drops mem_req_o for zero cycles: mem_req_o stays 1 and mem_we_o changes from 1 to 0.
- mem_ack_i while mem_req_o=0 is ignored.
- cpu_req_i=0 in IDLE: no state change, stall=0, cpu_data_o=0.
- Inputs must be held stable while stall=1; the pipeline guarantees this.
- Counters:
  - hit_cnt_o increments on every IDLE-state hit that is not the RETRY re-access; the re-access counts neither as hit nor as miss.
  - miss_cnt_o increments once per miss, on the IDLE to WB/ALLOC edge.
  - Both counters saturate at 32'hFFFF_FFFF.
- Reset (rst_i=0 at an edge), including mid-WB or mid-ALLOC:
  - State goes to IDLE; all valid and dirty bits clear; counters reset to 0.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0; cpu_stall_o=0 and cpu_data_o=0 while in reset.
  - A partially fetched line is discarded; an in-flight ack after reset is ignored.

Decomposition:
- Package dcache_pkg: state enum, offset width constant (5), word-select width constant (3), and the field-extract helper functions for tag and index.
- One natural sub-module: dcache_sram, holding the tag, valid, dirty and data arrays with a single read port and a single write port plus a word-write enable.
- The FSM, hit logic and counters stay in dcache_controller.

Test Plan:
- Cold load 0x0000_0040 with memory line = words 0..7 set to 0x100+i, ack after 3 cycles -> stall high for 5 cycles, then cpu_data_o=0x100; miss_cnt=1, hit_cnt=0.
- Load 0x44 after the cold load -> no stall, cpu_data_o=0x101, hit_cnt=1.
- Store 0xDEADBEEF to 0x48 -> no stall, line dirty.
- Then load 0x248 (same index 2, different tag) -> WB cycle with mem_addr_o=0x40 and mem_data_o word2=0xDEADBEEF, then ALLOC with mem_addr_o=0x240; miss_cnt=2.
- Spurious mem_ack_i pulse while IDLE -> no state, array or counter change.
- Assert rst_i=0 during ALLOC -> next edge mem_req_o=0 and state IDLE; reload of the same address misses again, with miss_cnt restarting at 1.
- Force hit_cnt to 0xFFFF_FFFF via a long hit loop (or bench backdoor), then perform one more hit -> hit_cnt_o stays 0xFFFF_FFFF.
